// File: rtl/stopwatch_timekeeper_if.sv
// Stopwatch bus: tick input, debounced buttons, divider enable and BCD display outputs.
interface stopwatch_timekeeper_if;
  logic       tick_clk;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       start_stop;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic [3:0] cs_t;
  logic [3:0] cs_o;
  logic       wrapped;
  logic       lap_active;

  modport master (
    output tick_clk, btn_start_stop, btn_clear, btn_lap,
    input  start_stop, min_t, min_o, sec_t, sec_o, cs_t, cs_o, wrapped, lap_active
  );

  modport slave (
    input  tick_clk, btn_start_stop, btn_clear, btn_lap,
    output start_stop, min_t, min_o, sec_t, sec_o, cs_t, cs_o, wrapped, lap_active
  );
endinterface

// File: rtl/stopwatch_timekeeper.sv
// MM:SS.cc BCD stopwatch with IDLE/RUN/PAUSE control driven by a synchronized 100 Hz tick.
// Optional lap (display freeze) feature compiled in with `define STOPWATCH_LAP_EN.
module stopwatch_timekeeper (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_timekeeper_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] ct;
    logic [3:0] co;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = 24'h595999;

  state_t    state_q, state_d;
  bcd_time_t count, count_d;
  bcd_time_t disp_q, disp_d;
  logic      wrapped_q, wrapped_d;
  logic      frozen_q, frozen_d;
  logic      start_stop_q;
  logic [1:0] rst_pipe;
  logic      rst_sync;
  logic      tick_s1, tick_s2, tick_hist;
  logic      ss_prev, clr_prev;
  logic      tick_ev, ss_edge, clr_edge, lap_edge;

  // Assert immediately, release two clk edges later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= '0;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_hist <= 1'b0;
      ss_prev   <= 1'b0;
      clr_prev  <= 1'b0;
    end else begin
      tick_s1   <= bus.tick_clk;
      tick_s2   <= tick_s1;
      tick_hist <= tick_s2;
      ss_prev   <= bus.btn_start_stop;
      clr_prev  <= bus.btn_clear;
    end
  end

  assign tick_ev  = tick_s2 & ~tick_hist;
  assign ss_edge  = bus.btn_start_stop & ~ss_prev;
  assign clr_edge = bus.btn_clear & ~clr_prev;

`ifdef STOPWATCH_LAP_EN
  logic lap_prev;
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) lap_prev <= 1'b0;
    else           lap_prev <= bus.btn_lap;
  end
  assign lap_edge = bus.btn_lap & ~lap_prev;
`else
  assign lap_edge = 1'b0;
`endif

  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t.co != 4'd9) n.co = 4'(t.co + 4'd1);
    else begin
      n.co = 4'd0;
      if (t.ct != 4'd9) n.ct = 4'(t.ct + 4'd1);
      else begin
        n.ct = 4'd0;
        if (t.so != 4'd9) n.so = 4'(t.so + 4'd1);
        else begin
          n.so = 4'd0;
          if (t.st != 4'd5) n.st = 4'(t.st + 4'd1);
          else begin
            n.st = 4'd0;
            if (t.mo != 4'd9) n.mo = 4'(t.mo + 4'd1);
            else begin
              n.mo = 4'd0;
              n.mt = (t.mt != 4'd5) ? 4'(t.mt + 4'd1) : 4'd0;
            end
          end
        end
      end
    end
    return n;
  endfunction

  // Next state, counter, wrap flag and freeze control
  always_comb begin
    state_d   = state_q;
    count_d   = count;
    wrapped_d = wrapped_q;
    frozen_d  = frozen_q;

    if (state_q == RUN && tick_ev) begin
      count_d = bcd_inc(count);
      if (count == TIME_MAX) wrapped_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (ss_edge) state_d = RUN;
      end
      RUN: begin
        if (ss_edge)  state_d  = PAUSE;
        if (lap_edge) frozen_d = ~frozen_q;
      end
      PAUSE: begin
        if (clr_edge) begin
          state_d   = IDLE;
          count_d   = '0;
          wrapped_d = 1'b0;
          frozen_d  = 1'b0;
        end else if (ss_edge) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold only while already frozen; a new freeze captures this edge's count
    disp_d = (frozen_q && frozen_d) ? disp_q : count_d;
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q      <= IDLE;
      count        <= '0;
      disp_q       <= '0;
      wrapped_q    <= 1'b0;
      frozen_q     <= 1'b0;
      start_stop_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count        <= count_d;
      disp_q       <= disp_d;
      wrapped_q    <= wrapped_d;
      frozen_q     <= frozen_d;
      start_stop_q <= (state_d != RUN);
    end
  end

  assign bus.start_stop = start_stop_q;
  assign bus.min_t      = disp_q.mt;
  assign bus.min_o      = disp_q.mo;
  assign bus.sec_t      = disp_q.st;
  assign bus.sec_o      = disp_q.so;
  assign bus.cs_t       = disp_q.ct;
  assign bus.cs_o       = disp_q.co;
  assign bus.wrapped    = wrapped_q;
  assign bus.lap_active = frozen_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Directed self-checking bench for stopwatch_timekeeper; lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_timekeeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  stopwatch_timekeeper_if bus ();

  stopwatch_timekeeper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] disp();
    return {8'h00, bus.min_t, bus.min_o, bus.sec_t, bus.sec_o, bus.cs_t, bus.cs_o};
  endfunction

  // One tick_clk period: two clk cycles high, two low; increment lands before return
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.tick_clk = 1'b1;
      repeat (2) @(negedge clk);
      bus.tick_clk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic press(input logic ss, input logic clr, input logic lap);
    @(negedge clk);
    bus.btn_start_stop = ss;
    bus.btn_clear      = clr;
    bus.btn_lap        = lap;
    @(negedge clk);
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    bus.btn_lap        = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_disp"}, disp(), 32'h0);
    check({tag, "_ss"}, 32'(bus.start_stop), 32'd1);
    check({tag, "_wrap"}, 32'(bus.wrapped), 32'd0);
    check({tag, "_lap"}, 32'(bus.lap_active), 32'd0);
  endtask

  initial begin
    bus.tick_clk       = 1'b0;
    bus.btn_start_stop = 1'b0;
    bus.btn_clear      = 1'b0;
    bus.btn_lap        = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Basic run and pause
    press(1, 0, 0);
    check("run_ss", 32'(bus.start_stop), 32'd0);
    do_ticks(150);
    check("run150", disp(), 32'h000150);
    check("run150_ss", 32'(bus.start_stop), 32'd0);
    press(1, 0, 0);
    do_ticks(10);
    check("pause_hold", disp(), 32'h000150);
    check("pause_ss", 32'(bus.start_stop), 32'd1);
    press(1, 0, 0);
    do_ticks(1);
    check("resume", disp(), 32'h000151);
    press(1, 0, 0);
    press(0, 1, 0);
    check("clr1", disp(), 32'h0);

    // Clear rules
    press(1, 0, 0);
    do_ticks(30);
    press(0, 1, 0);
    check("clr_run", disp(), 32'h000030);
    check("clr_run_ss", 32'(bus.start_stop), 32'd0);
    do_ticks(1);
    check("clr_run_still", disp(), 32'h000031);
    press(1, 0, 0);
    press(0, 1, 0);
    check("clr_pause", disp(), 32'h0);
    check("clr_pause_ss", 32'(bus.start_stop), 32'd1);
    press(0, 1, 0);
    do_ticks(5);
    check("clr_idle", disp(), 32'h0);
    check("clr_idle_ss", 32'(bus.start_stop), 32'd1);

    // Tick and start_stop on the same edge
    press(1, 0, 0);
    do_ticks(7);
    check("sim_pre", disp(), 32'h000007);
    @(negedge clk) bus.tick_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.tick_clk       = 1'b0;
    bus.btn_start_stop = 1'b1;
    @(negedge clk) bus.btn_start_stop = 1'b0;
    repeat (2) @(negedge clk);
    check("sim_tick", disp(), 32'h000008);
    check("sim_ss", 32'(bus.start_stop), 32'd1);
    do_ticks(3);
    check("sim_paused", disp(), 32'h000008);
    press(1, 1, 0);
    check("sim_clr_pri", disp(), 32'h0);
    check("sim_clr_ss", 32'(bus.start_stop), 32'd1);

    // Lap freeze
    press(1, 0, 0);
    do_ticks(20);
    press(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    check("lap_on", 32'(bus.lap_active), 32'd1);
    do_ticks(30);
    check("lap_frozen", disp(), 32'h000020);
    press(0, 0, 1);
    check("lap_off", 32'(bus.lap_active), 32'd0);
    check("lap_live", disp(), 32'h000050);
`else
    check("lap_none", 32'(bus.lap_active), 32'd0);
    do_ticks(30);
    check("lap_live", disp(), 32'h000050);
    press(0, 0, 1);
    check("lap_none2", 32'(bus.lap_active), 32'd0);
    check("lap_live2", disp(), 32'h000050);
`endif
    press(1, 0, 0);
    press(0, 1, 0);

    // Carry into minutes, then rollover from 59:59.99
    press(1, 0, 0);
    do_ticks(5999);
    check("carry_pre", disp(), 32'h005999);
    do_ticks(1);
    check("carry_min", disp(), 32'h010000);
    check("carry_wrap", 32'(bus.wrapped), 32'd0);
    @(negedge clk);
    force dut.count = 24'h595999;
    @(negedge clk);
    release dut.count;
    @(negedge clk);
    do_ticks(1);
    check("roll", disp(), 32'h000000);
    check("roll_wrap", 32'(bus.wrapped), 32'd1);
    do_ticks(1);
    check("roll_run", disp(), 32'h000001);
    press(1, 0, 0);
    check("roll_wrap_pause", 32'(bus.wrapped), 32'd1);
    press(0, 1, 0);
    check("roll_wrap_clr", 32'(bus.wrapped), 32'd0);

    // Asynchronous reset mid-run with a tick in flight
    press(1, 0, 0);
    do_ticks(1234);
    check("areset_pre", disp(), 32'h001234);
    @(negedge clk) bus.tick_clk = 1'b1;
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check_reset_values("areset");
    bus.tick_clk = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values("post_reset");
    press(1, 0, 0);
    do_ticks(1);
    check("post_reset_run", disp(), 32'h000001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stopwatch_timekeeper.md
STOPWATCH_TIMEKEEPER -- requirements
Module: stopwatch_timekeeper

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- tick_clk  in  1  100 Hz square wave from the clock divider; asynchronous to clk.
- btn_start_stop  in  1  level, active-high, already debounced.
- btn_clear  in  1  level, active-high, already debounced.
- btn_lap  in  1  level, active-high, already debounced.
- start_stop  out  1  divider enable; 0 = divider runs, 1 = divider halted.
- min_t, min_o  out  4 each  minutes, BCD tens and ones.
- sec_t, sec_o  out  4 each  seconds, BCD tens and ones.
- cs_t, cs_o  out  4 each  centiseconds, BCD tens and ones.
- wrapped  out  1  sticky flag: counter rolled over past 59:59.99.
- lap_active  out  1  display currently frozen.

Function
REQ-002 tick_clk SHALL pass through a two-flop synchronizer plus one history flop; a tick event SHALL be a synchronized 0->1 transition.
REQ-003 The time counter SHALL update on the 3rd rising clk edge that samples tick_clk high; one tick event SHALL cause exactly one increment.
REQ-004 Each button SHALL be edge-detected (high this cycle, low the previous cycle); its action SHALL take effect on that same clk edge; a held button SHALL act once.
REQ-005 The FSM SHALL have the states IDLE, RUN and PAUSE.
REQ-006 FSM transitions:
- IDLE + start_stop edge -> RUN.
- RUN + start_stop edge -> PAUSE.
- PAUSE + start_stop edge -> RUN.
- PAUSE + clear edge -> IDLE.
- All other button edges SHALL leave the state unchanged.
REQ-007 Clear in IDLE SHALL be ignored, and clear in RUN SHALL be ignored.
REQ-008 start_stop SHALL be registered: 0 in RUN, 1 in IDLE and PAUSE.
REQ-009 Counting rules:
- Increment only when the state is RUN at the tick edge.
- Ticks in IDLE or PAUSE SHALL be discarded and not deferred.
REQ-010 Digit ranges:
- cs 00-99, carrying into sec.
- sec 00-59, carrying into min.
- min 00-59.
- All six digits SHALL always hold valid BCD (0-9, tens of sec and min 0-5).
REQ-011 Rollover: 59:59.99 + 1 tick SHALL give 00:00.00 and set wrapped; the counter keeps running.
REQ-012 wrapped SHALL clear only on the PAUSE->IDLE transition or on reset.
REQ-013 Entering IDLE SHALL zero all digits.
REQ-014 Simultaneous events:
- Tick and start_stop edge in the same cycle in RUN: the increment SHALL be applied and the state SHALL go to PAUSE.
- start_stop and clear edges in the same cycle in PAUSE: clear SHALL take priority, giving IDLE.
- start_stop and clear edges in the same cycle in RUN: the state SHALL go to PAUSE and clear SHALL be ignored.
REQ-015 Display outputs SHALL be registered and SHALL show the live counter unless frozen per REQ-020.

Reset
REQ-016 Reset assertion SHALL be asynchronous; release SHALL be synchronous to clk.
REQ-017 Reset values:
- State IDLE.
- start_stop = 1.
- All digits 0.
- wrapped = 0.
- lap_active = 0.
- Synchronizer and edge-history flops 0.
REQ-018 A reset during RUN SHALL discard the count and any pending tick.

Configuration
REQ-019 The macro STOPWATCH_LAP_EN SHALL select whether the lap feature is compiled in.
REQ-020 With STOPWATCH_LAP_EN defined:
- A lap edge in RUN SHALL toggle the freeze.
- Freezing SHALL latch the current counter into the display registers and set lap_active; the internal counter keeps counting.
- Unfreezing SHALL clear lap_active and resume the live display on the next edge.
- A lap edge in IDLE or PAUSE SHALL be ignored; the freeze SHALL persist through PAUSE.
- PAUSE->IDLE SHALL clear the freeze.
REQ-021 Without STOPWATCH_LAP_EN: btn_lap SHALL be unused, lap_active SHALL be constant 0, and the display SHALL always be live.

Verification
REQ-022 Basic run and pause: reset, then start, then 150 tick_clk rising edges -> digits 00:01.50, start_stop = 0; then stop and 10 more ticks -> still 00:01.50, start_stop = 1.
REQ-023 Carry and rollover: preload by ticking to 00:59.99, then 1 tick -> 01:00.00; continue to 59:59.99, then 1 tick -> 00:00.00 with wrapped = 1.
REQ-024 Clear rules: clear in RUN at 00:00.30 -> no change; stop, then clear -> IDLE with 00:00.00 and wrapped = 0; clear in IDLE -> no effect.
REQ-025 Simultaneity: a start_stop edge in the same cycle as a tick at 00:00.07 -> 00:00.08 and PAUSE; start_stop and clear edges together in PAUSE -> IDLE.
REQ-026 Lap (with STOPWATCH_LAP_EN): lap at 00:00.20, then 30 ticks -> display 00:00.20 with lap_active = 1; lap again -> display 00:00.50 with lap_active = 0. Without the macro: lap edges change nothing.
REQ-027 Asynchronous reset: assert rst mid-RUN at 00:12.34 -> all outputs reach their reset values immediately, without waiting for a clk edge.
